shift_in_165: RTL and testbench
===============================

SHIFT_IN_165 -- requirements
Module: shift_in_165

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits captured per read (chain length of 74HC165 stages).
REQ-002 The block SHALL have parameter CLK_DIV, default 2, meaning i_clk cycles per half-period of o_CLK and per o_SH_LD phase; legal range is 1 and up.

Interface
REQ-003 The block SHALL have port i_clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port i_Start, input, 1 bit: read request, sampled only while o_Ready=1.
REQ-006 The block SHALL have port i_QH, input, 1 bit: serial data from the 74HC165 QH pin.
REQ-007 The block SHALL have port o_SH_LD, output, 1 bit: 74HC165 SH/LD, where 0 means parallel load.
REQ-008 The block SHALL have port o_CLK, output, 1 bit: 74HC165 shift clock.
REQ-009 The block SHALL have port o_Ready, output, 1 bit: high when idle and able to accept i_Start.
REQ-010 The block SHALL have port o_Valid, output, 1 bit: one-cycle pulse marking new o_Data.
REQ-011 The block SHALL have port o_Data, output, WIDTH bits: last captured word, where bit WIDTH-1 is the first bit shifted out (device input D7).

Function
REQ-012 The block SHALL implement the states IDLE, LOAD, SETTLE, LOW, HIGH and DONE, all registered.
- Every output SHALL be driven from a register.
- The phase counter SHALL be $clog2(CLK_DIV+1) bits wide.
- The bit counter SHALL be $clog2(WIDTH+1) bits wide.
REQ-013 IDLE
- Outputs: o_SH_LD=1, o_CLK=0, o_Ready=1, o_Valid=0.
- i_Start=1 on a rising edge: go to LOAD and drop o_Ready to 0 on that same edge.
REQ-014 LOAD
- o_SH_LD=0 for exactly CLK_DIV cycles.
- Then go to SETTLE.
REQ-015 SETTLE
- o_SH_LD=1 and o_CLK=0 for exactly CLK_DIV cycles.
- Then go to LOW.
REQ-016 LOW
- o_CLK=0 for CLK_DIV cycles.
- On the last of these cycles, sample i_QH and shift it into the LSB of the internal shift register (MSB-first order), then increment the bit count.
- If bit count is now WIDTH: go to DONE.
- Otherwise: go to HIGH.
REQ-017 HIGH
- o_CLK=1 for CLK_DIV cycles.
- Then go to LOW.
- Exactly WIDTH-1 rising edges of o_CLK SHALL occur per read.
- o_CLK SHALL end low.
REQ-018 DONE
- Lasts one cycle: o_Data receives the shift register, o_Valid=1, o_Ready=0.
- Then go to IDLE.
REQ-019 Latency: o_Valid SHALL be high in the cycle after rising edge number CLK_DIV*(2*WIDTH+1)+1, counting the i_Start-sampling edge as edge 0.
- For the defaults this is edge 35.
- In IDLE, a new i_Start SHALL be accepted at the earliest on the edge after DONE.
REQ-020 i_Start SHALL be ignored in every state other than IDLE; there is no queuing.
- i_Start held high SHALL produce back-to-back reads separated by one IDLE cycle.
REQ-021 o_Data SHALL hold its value between reads and change only in DONE.
REQ-022 i_QH SHALL be treated as synchronous, with no synchronizer in the block.
- The CLK_DIV-cycle low phase before each sample SHALL give the device settle time.

Reset
REQ-023 Assertion of i_rst_n=0 SHALL immediately force, independent of i_clk:
- state IDLE and counters 0;
- o_SH_LD=1, o_CLK=0, o_Ready=1, o_Valid=0;
- o_Data=0 and the internal shift register 0.
REQ-024 Reset asserted mid-read SHALL abort the read with no o_Valid pulse.
- The first i_Start after release SHALL start a complete new read from LOAD.

Verification
REQ-025 The bench SHALL use a 74HC165 model with the following behaviour:
- o_SH_LD=0 loads the parallel inputs.
- A rising edge of o_CLK with o_SH_LD=1 shifts toward QH.
- i_QH is stage 7.
REQ-026 Reset: hold i_rst_n=0 -> o_SH_LD=1, o_CLK=0, o_Ready=1, o_Valid=0, o_Data=0x00.
REQ-027 Single read with defaults and parallel input 0xA5, i_Start pulsed one cycle:
- o_SH_LD is low for exactly 2 cycles.
- 7 o_CLK rising edges occur.
- o_Valid is high for exactly 1 cycle after edge 35.
- o_Data=0xA5.
REQ-028 Bit order: reads of 0x01 then 0x80 with i_Start held high -> o_Data=0x01 then 0x80, with the two o_Valid pulses 36 cycles apart.
REQ-029 Busy ignore: i_Start pulsed at edges 0 and 10 with input 0x3C -> exactly one o_Valid pulse and o_Data=0x3C.
REQ-030 Reset mid-shift: assert i_rst_n=0 at edge 20 of a 0xFF read ->
- outputs go idle at once, with no o_Valid and o_Data=0x00;
- a following read of 0x5A returns 0x5A.
REQ-031 CLK_DIV=1 with reads of 0xFF and then 0x00 -> o_Valid follows each start after edge 18, with o_Data=0xFF and then 0x00.

Source files
------------

// File: rtl/shift_in_165.sv
// shift_in_165: reads a 74HC165 chain by loading it in parallel and then clocking it out MSB-first.
module shift_in_165 #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_Start,
  input  logic             i_QH,
  output logic             o_SH_LD,
  output logic             o_CLK,
  output logic             o_Ready,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, LOW, HIGH, DONE} state_t;
  state_t           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d, ph_nxt;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sr_q, sr_d, data_q, data_d;
  logic             sh_ld_q, clk_q, ready_q, valid_q, ph_end;
  assign ph_end  = ph_q == PW'(CLK_DIV - 1);
  assign ph_nxt  = ph_end ? '0 : ph_q + PW'(1);
  assign o_SH_LD = sh_ld_q;
  assign o_CLK   = clk_q;
  assign o_Ready = ready_q;
  assign o_Valid = valid_q;
  assign o_Data  = data_q;
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (i_Start) begin
        state_d = LOAD;
        ph_d    = '0;
        bit_d   = '0;
      end
      LOAD: begin
        ph_d    = ph_nxt;
        state_d = ph_end ? SETTLE : LOAD;
      end
      SETTLE: begin
        ph_d    = ph_nxt;
        state_d = ph_end ? LOW : SETTLE;
      end
      LOW: begin
        ph_d = ph_nxt;
        // sample at the end of the low phase so QH has had the full phase to settle
        if (ph_end) begin
          sr_d    = WIDTH'({sr_q, i_QH});
          bit_d   = bit_q + BW'(1);
          state_d = (bit_q == BW'(WIDTH - 1)) ? DONE : HIGH;
        end
      end
      HIGH: begin
        ph_d    = ph_nxt;
        state_d = ph_end ? LOW : HIGH;
      end
      DONE: begin
        data_d  = sr_q;
        bit_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      sh_ld_q <= 1'b1;
      clk_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      sh_ld_q <= state_d != LOAD;
      clk_q   <= state_d == HIGH;
      ready_q <= state_d == IDLE;
      // the word is published as DONE ends, so the pulse lands in the following cycle
      valid_q <= state_q == DONE;
    end
  end
endmodule

// File: tb/tb_shift_in_165.sv
// tb_shift_in_165: drives two readers (default and CLK_DIV=1) against 74HC165 models.
module tb_shift_in_165;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start0 = 1'b0, start1 = 1'b0, qh0, qh1, sh0, sh1, ck0, ck1, rdy0, rdy1, vld0, vld1;
  logic [7:0] d0, d1, par0 = 8'h00, par1 = 8'h00, sr0 = 8'h00, sr1 = 8'h00;
  logic pck0 = 1'b0, pck1 = 1'b0;
  int errors = 0, checks = 0;
  localparam int LAT0 = 2 * (2 * 8 + 1) + 1;
  localparam int LAT1 = 1 * (2 * 8 + 1) + 1;

  shift_in_165 dut0 (.i_clk(clk), .i_rst_n(rst_n), .i_Start(start0), .i_QH(qh0), .o_SH_LD(sh0),
                     .o_CLK(ck0), .o_Ready(rdy0), .o_Valid(vld0), .o_Data(d0));
  shift_in_165 #(.WIDTH(8), .CLK_DIV(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .i_Start(start1), .i_QH(qh1),
                     .o_SH_LD(sh1), .o_CLK(ck1), .o_Ready(rdy1), .o_Valid(vld1), .o_Data(d1));

  // 74HC165 models: SH/LD low loads, rising CLK with SH/LD high shifts toward QH
  assign qh0 = sr0[7];
  assign qh1 = sr1[7];
  always @(posedge clk) begin
    #1;
    if (!sh0) sr0 = par0;
    else if (ck0 && !pck0) sr0 = {sr0[6:0], 1'b0};
    pck0 = ck0;
    if (!sh1) sr1 = par1;
    else if (ck1 && !pck1) sr1 = {sr1[6:0], 1'b0};
    pck1 = ck1;
  end

  task automatic run0(input logic [7:0] par, input int win, output int vedge, output int nv,
                      output int lo, output int rises, output logic [7:0] last, output logic rdy_e0);
    logic prev;
    par0 = par;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    rdy_e0 = rdy0;
    vedge = -1; nv = 0; lo = 0; rises = 0; last = 8'hxx; prev = ck0;
    for (int n = 0; n <= win; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (!sh0) lo++;
      if (ck0 && !prev) rises++;
      prev = ck0;
      if (vld0) begin
        nv++;
        last = d0;
        if (vedge < 0) vedge = n;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sh0 !== 1'b1) begin errors++; $display("FAIL reset_sh_ld got=%b exp=1", sh0); end
    checks++; if (ck0 !== 1'b0) begin errors++; $display("FAIL reset_clk got=%b exp=0", ck0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vld0); end
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", d0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int ve, nv, lo, ri;
    logic [7:0] last;
    logic r0;
    run0(8'hA5, 45, ve, nv, lo, ri, last, r0);
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL single_ready_drop got=%b exp=0", r0); end
    checks++; if (lo != 2) begin errors++; $display("FAIL single_shld_low got=%0d exp=2", lo); end
    checks++; if (ri != 7) begin errors++; $display("FAIL single_clk_rises got=%0d exp=7", ri); end
    checks++; if (ve != LAT0) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", ve, LAT0); end
    checks++; if (nv != 1) begin errors++; $display("FAIL single_valid_count got=%0d exp=1", nv); end
    checks++; if (last !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", last); end
    checks++; if (ck0 !== 1'b0 || d0 !== 8'hA5) begin
      errors++; $display("FAIL single_idle_hold clk=%b data=%h exp clk=0 data=a5", ck0, d0);
    end
  endtask

  task automatic test_random;
    int ve, nv, lo, ri;
    logic [7:0] last, p;
    logic r0;
    for (int k = 0; k < 6; k++) begin
      p = 8'($urandom);
      run0(p, 40, ve, nv, lo, ri, last, r0);
      checks++; if (last !== p || nv != 1 || ve != LAT0) begin
        errors++; $display("FAIL random_read%0d data=%h nv=%0d edge=%0d exp data=%h nv=1 edge=%0d", k, last, nv, ve, p, LAT0);
      end
    end
  endtask

  task automatic test_back_to_back;
    int ve[$];
    logic [7:0] dv[$];
    par0 = 8'h01;
    @(negedge clk);
    start0 = 1'b1;
    for (int n = 0; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (n == 5) par0 = 8'h80;
      if (n == 40) start0 = 1'b0;
      if (vld0) begin
        ve.push_back(n);
        dv.push_back(d0);
      end
    end
    checks++; if (ve.size() != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", ve.size()); end
    else begin
      checks++; if (dv[0] !== 8'h01) begin errors++; $display("FAIL b2b_first got=%h exp=01", dv[0]); end
      checks++; if (dv[1] !== 8'h80) begin errors++; $display("FAIL b2b_second got=%h exp=80", dv[1]); end
      checks++; if (ve[1] - ve[0] != LAT0 + 1) begin
        errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", ve[1] - ve[0], LAT0 + 1);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int nv = 0, ve = -1;
    logic [7:0] last = 8'h00;
    par0 = 8'h3C;
    for (int n = 0; n <= 80; n++) begin
      @(negedge clk);
      start0 = (n == 0 || n == 10);
      @(posedge clk);
      #1;
      start0 = 1'b0;
      if (vld0) begin
        nv++;
        last = d0;
        if (ve < 0) ve = n;
      end
    end
    checks++; if (nv != 1) begin errors++; $display("FAIL busy_pulses got=%0d exp=1", nv); end
    checks++; if (last !== 8'h3C) begin errors++; $display("FAIL busy_data got=%h exp=3c", last); end
    checks++; if (ve != LAT0) begin errors++; $display("FAIL busy_latency got=%0d exp=%0d", ve, LAT0); end
  endtask

  task automatic test_reset_mid;
    int ve, nv, lo, ri, sv = 0;
    logic [7:0] last;
    logic r0;
    par0 = 8'hFF;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (sh0 !== 1'b1 || ck0 !== 1'b0 || rdy0 !== 1'b1 || vld0 !== 1'b0) begin
      errors++; $display("FAIL midreset_idle sh=%b clk=%b rdy=%b vld=%b exp 1 0 1 0", sh0, ck0, rdy0, vld0);
    end
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL midreset_data got=%h exp=00", d0); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (vld0) sv++;
    end
    checks++; if (sv != 0) begin errors++; $display("FAIL midreset_no_valid got=%0d exp=0", sv); end
    run0(8'h5A, 40, ve, nv, lo, ri, last, r0);
    checks++; if (last !== 8'h5A || ve != LAT0 || lo != 2) begin
      errors++; $display("FAIL midreset_reread data=%h edge=%0d lo=%0d exp data=5a edge=%0d lo=2", last, ve, lo, LAT0);
    end
  endtask

  task automatic test_clkdiv1;
    logic [7:0] pats [2];
    pats[0] = 8'hFF;
    pats[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      int ve = -1, nv = 0;
      logic [7:0] last = 8'hxx;
      par1 = pats[k];
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int n = 1; n <= 24; n++) begin
        @(posedge clk);
        #1;
        if (vld1) begin
          nv++;
          last = d1;
          if (ve < 0) ve = n;
        end
      end
      checks++; if (ve != LAT1 || nv != 1) begin
        errors++; $display("FAIL div1_latency%0d edge=%0d nv=%0d exp edge=%0d nv=1", k, ve, nv, LAT1);
      end
      checks++; if (last !== pats[k]) begin errors++; $display("FAIL div1_data%0d got=%h exp=%h", k, last, pats[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
